// File: rtl/simd_addsub_pipe.sv
// rtl/simd_addsub_pipe.sv - 2-stage valid/ready lane-split SIMD add/sub with optional saturation
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_i / ready_o        input handshake
//   op_i                     00 ADD, 01 SUB, 10 ADD_SAT, 11 SUB_SAT
//   signed_i                 saturation bounds: 1 signed, 0 unsigned
//   sew_i                    lane width = MIN_WIDTH << sew_i (clamped to MAX_WIDTH)
//   opA_i, opB_i             operands
//   valid_o / ready_i        output handshake
//   result_o                 lane-wise result
//   carry_o, satf_o          per-slot flags, only in the top slot of each lane
//   sat_sticky_o, clr_sat_i  sticky saturation status and its clear
module simd_addsub_pipe #(
  parameter  int MIN_WIDTH = 8,
  parameter  int MAX_WIDTH = 64,
  localparam int RATIO     = MAX_WIDTH / MIN_WIDTH,
  localparam int SEW_WIDTH = $clog2(RATIO) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           op_i,
  input  logic                 signed_i,
  input  logic [SEW_WIDTH-1:0] sew_i,
  input  logic [MAX_WIDTH-1:0] opA_i,
  input  logic [MAX_WIDTH-1:0] opB_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [MAX_WIDTH-1:0] result_o,
  output logic [RATIO-1:0]     carry_o,
  output logic [RATIO-1:0]     satf_o,
  output logic                 sat_sticky_o,
  input  logic                 clr_sat_i
);

  localparam int                   LOG2R   = $clog2(RATIO);
  localparam logic [SEW_WIDTH-1:0] SEW_MAX = SEW_WIDTH'(LOG2R);

  // Clamp kinds recorded per lane top slot
  localparam logic [2:0] K_NONE = 3'd0;
  localparam logic [2:0] K_ONES = 3'd1;
  localparam logic [2:0] K_ZERO = 3'd2;
  localparam logic [2:0] K_MAXP = 3'd3;
  localparam logic [2:0] K_MINN = 3'd4;

  logic                 r_s1_valid;
  logic [MAX_WIDTH-1:0] r_s1_a;
  logic [MAX_WIDTH-1:0] r_s1_b;
  logic [1:0]           r_s1_op;
  logic                 r_s1_signed;
  logic [SEW_WIDTH-1:0] r_s1_sew;

  logic                 r_s2_valid;
  logic [MAX_WIDTH-1:0] r_result;
  logic [RATIO-1:0]     r_carry;
  logic [RATIO-1:0]     r_satf;
  logic                 r_sticky;

  logic                 w_s2_load;
  logic                 w_s1_load;
  logic                 w_sub;
  logic                 w_sat_op;
  logic [SEW_WIDTH-1:0] w_sew_eff;
  logic [31:0]          w_lane_mask;

  logic [MAX_WIDTH-1:0] w_sum;
  logic [RATIO-1:0]     w_cout;
  logic [3*RATIO-1:0]   w_kind;
  logic                 w_cin;
  logic [MIN_WIDTH-1:0] w_a_s;
  logic [MIN_WIDTH-1:0] w_b_s;
  logic [MIN_WIDTH-1:0] w_bx_s;
  logic [MIN_WIDTH:0]   w_ext;
  logic                 w_ovf;

  logic [MAX_WIDTH-1:0] w_res;
  logic [RATIO-1:0]     w_carry;
  logic [RATIO-1:0]     w_satf;
  logic [2:0]           w_k;
  int                   w_top;

  assign w_s2_load = !r_s2_valid || ready_i;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign ready_o   = !rst && w_s1_load;

  assign w_sub       = r_s1_op[0];
  assign w_sat_op    = r_s1_op[1];
  assign w_sew_eff   = (r_s1_sew > SEW_MAX) ? SEW_MAX : r_s1_sew;
  // Low bits set for slots that share one lane; slot k is a lane start when
  // (k & mask) == 0 and the lane top when (k & mask) == mask.
  assign w_lane_mask = (32'd1 << w_sew_eff) - 32'd1;

  // Slot-serial adder: carry ripples between slots, reseeded with the
  // subtract carry-in at every lane start so lanes never interact.
  always_comb begin
    w_sum  = '0;
    w_cout = '0;
    w_kind = '0;
    w_cin  = 1'b0;
    w_a_s  = '0;
    w_b_s  = '0;
    w_bx_s = '0;
    w_ext  = '0;
    w_ovf  = 1'b0;
    for (int k = 0; k < RATIO; k++) begin
      w_a_s  = r_s1_a[k*MIN_WIDTH +: MIN_WIDTH];
      w_b_s  = r_s1_b[k*MIN_WIDTH +: MIN_WIDTH];
      w_bx_s = w_sub ? ~w_b_s : w_b_s;
      if ((32'(k) & w_lane_mask) == 32'd0) w_cin = w_sub;
      w_ext = {1'b0, w_a_s} + {1'b0, w_bx_s} + {{MIN_WIDTH{1'b0}}, w_cin};
      w_sum[k*MIN_WIDTH +: MIN_WIDTH] = w_ext[MIN_WIDTH-1:0];
      w_cout[k] = w_ext[MIN_WIDTH];
      w_cin     = w_ext[MIN_WIDTH];
      if (((32'(k) & w_lane_mask) == w_lane_mask) && w_sat_op) begin
        if (r_s1_signed) begin
          // Overflow when both addend signs agree (B already inverted for SUB)
          // and the result sign differs from them.
          w_ovf = ~(w_a_s[MIN_WIDTH-1] ^ w_bx_s[MIN_WIDTH-1]) &
                   (w_ext[MIN_WIDTH-1] ^ w_a_s[MIN_WIDTH-1]);
          if (w_ovf) w_kind[k*3 +: 3] = w_a_s[MIN_WIDTH-1] ? K_MINN : K_MAXP;
        end else if (w_sub) begin
          if (!w_ext[MIN_WIDTH]) w_kind[k*3 +: 3] = K_ZERO;
        end else begin
          if (w_ext[MIN_WIDTH]) w_kind[k*3 +: 3] = K_ONES;
        end
      end
    end
  end

  // Apply the lane decision (held in the lane's top slot) to every slot.
  always_comb begin
    w_res   = w_sum;
    w_carry = '0;
    w_satf  = '0;
    w_k     = K_NONE;
    w_top   = 0;
    for (int k = 0; k < RATIO; k++) begin
      w_top = int'(32'(k) | w_lane_mask);
      w_k   = w_kind[w_top*3 +: 3];
      if (w_top == k) begin
        w_carry[k] = w_cout[k];
        w_satf[k]  = (w_k != K_NONE);
      end
      case (w_k)
        K_ONES:  w_res[k*MIN_WIDTH +: MIN_WIDTH] = '1;
        K_ZERO:  w_res[k*MIN_WIDTH +: MIN_WIDTH] = '0;
        K_MAXP:  w_res[k*MIN_WIDTH +: MIN_WIDTH] = (w_top == k) ? {1'b0, {(MIN_WIDTH-1){1'b1}}} : '1;
        K_MINN:  w_res[k*MIN_WIDTH +: MIN_WIDTH] = (w_top == k) ? {1'b1, {(MIN_WIDTH-1){1'b0}}} : '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_op     <= '0;
      r_s1_signed <= 1'b0;
      r_s1_sew    <= '0;
      r_s2_valid  <= 1'b0;
      r_result    <= '0;
      r_carry     <= '0;
      r_satf      <= '0;
      r_sticky    <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= valid_i;
        if (valid_i) begin
          r_s1_a      <= opA_i;
          r_s1_b      <= opB_i;
          r_s1_op     <= op_i;
          r_s1_signed <= signed_i;
          r_s1_sew    <= sew_i;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result <= w_res;
          r_carry  <= w_carry;
          r_satf   <= w_satf;
        end
      end
      // A saturating output transfer beats a simultaneous clear.
      if (r_s2_valid && ready_i && (|r_satf)) r_sticky <= 1'b1;
      else if (clr_sat_i)                     r_sticky <= 1'b0;
    end
  end

  assign valid_o      = r_s2_valid;
  assign result_o     = r_result;
  assign carry_o      = r_carry;
  assign satf_o       = r_satf;
  assign sat_sticky_o = r_sticky;

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// tb/tb_simd_addsub_pipe.sv - scoreboard bench for simd_addsub_pipe
module tb_simd_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic        signed_i;
  logic [3:0]  sew_i;
  logic [63:0] opA_i;
  logic [63:0] opB_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] result_o;
  logic [7:0]  carry_o;
  logic [7:0]  satf_o;
  logic        sat_sticky_o;
  logic        clr_sat_i;

  simd_addsub_pipe #(.MIN_WIDTH(8), .MAX_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .signed_i(signed_i), .sew_i(sew_i), .opA_i(opA_i), .opB_i(opB_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .carry_o(carry_o),
    .satf_o(satf_o), .sat_sticky_o(sat_sticky_o), .clr_sat_i(clr_sat_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [7:0]  cy;
    logic [7:0]  sf;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   cycle    = 0;
  bit   done;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: whole-lane integer arithmetic with range-based clamping.
  function automatic exp_t model(input logic [1:0] op, input logic sg, input logic [3:0] sew,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int w;
    int spl;
    logic [66:0] m, ua, ub, us, lane;
    logic signed [66:0] sa, sbv, t, hi, lo;
    logic sat;
    e.res = '0; e.cy = '0; e.sf = '0; e.cyc = 0; e.lat = 1'b0;
    w   = (sew > 4'd3) ? 64 : (8 << sew);
    spl = w / 8;
    m   = (67'd1 << w) - 67'd1;
    for (int l = 0; l < 64 / w; l++) begin
      ua   = ({3'b0, a} >> (l * w)) & m;
      ub   = ({3'b0, b} >> (l * w)) & m;
      us   = op[0] ? ua + (~ub & m) + 67'd1 : ua + ub;
      e.cy[l*spl + spl - 1] = us[w];
      lane = us & m;
      sat  = 1'b0;
      if (op[1]) begin
        if (!sg) begin
          if (!op[0] && (ua + ub > m)) begin lane = m;   sat = 1'b1; end
          if (op[0] && (ua < ub))      begin lane = '0;  sat = 1'b1; end
        end else begin
          sa  = $signed(ua);
          sbv = $signed(ub);
          if (ua[w-1]) sa  = sa  - $signed(m) - 67'sd1;
          if (ub[w-1]) sbv = sbv - $signed(m) - 67'sd1;
          t  = op[0] ? sa - sbv : sa + sbv;
          hi = $signed(m >> 1);
          lo = -hi - 67'sd1;
          if (t > hi)      begin lane = m >> 1;        sat = 1'b1; end
          else if (t < lo) begin lane = (m >> 1) ^ m;  sat = 1'b1; end
        end
      end
      e.sf[l*spl + spl - 1] = sat;
      e.res = e.res | 64'(lane << (l * w));
    end
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid_o && ready_i) begin
        n_out++;
        if (sbq.size() == 0) begin
          check("out_when_idle", 64'(valid_o), 64'd0);
        end else begin
          e = sbq.pop_front();
          check("result", result_o, e.res);
          check("carry", 64'(carry_o), 64'(e.cy));
          check("satf", 64'(satf_o), 64'(e.sf));
          if (e.lat) check("latency", 64'(cycle - e.cyc), 64'd2);
        end
      end
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic sg, input logic [3:0] sew,
                       input logic [63:0] a, input logic [63:0] b, input exp_t e);
    int n;
    valid_i = 1'b1; op_i = op; signed_i = sg; sew_i = sew; opA_i = a; opB_i = b;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      check("ready_timeout", 64'(ready_o), 64'd1);
    end else begin
      e.cyc = cycle;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic send_m(input logic [1:0] op, input logic sg, input logic [3:0] sew,
                        input logic [63:0] a, input logic [63:0] b, input bit lat);
    exp_t e;
    e = model(op, sg, sew, a, b);
    e.lat = lat;
    drive(op, sg, sew, a, b, e);
  endtask

  task automatic send_x(input logic [1:0] op, input logic sg, input logic [3:0] sew,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] xr, input logic [7:0] xc, input logic [7:0] xs);
    exp_t e;
    e.res = xr; e.cy = xc; e.sf = xs; e.cyc = 0; e.lat = 1'b1;
    drive(op, sg, sew, a, b, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(valid_o), 64'd1);
  endtask

  function automatic logic [63:0] rnd_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'h7F7F_7F7F_7F7F_7F7F;
      1:       v = 64'h8080_8080_8080_8080;
      2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      3:       v = 64'h0;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] held;
    int          base;
    rst = 1'b1; valid_i = 1'b0; op_i = 2'b00; signed_i = 1'b0; sew_i = 4'd0;
    opA_i = '0; opB_i = '0; ready_i = 1'b1; clr_sat_i = 1'b0; done = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_rst", 64'(ready_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_carry", 64'(carry_o), 64'd0);
    check("rst_satf", 64'(satf_o), 64'd0);
    check("rst_sticky", 64'(sat_sticky_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;

    // Byte lanes all carry out and wrap to zero
    send_x(2'b00, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101,
           64'h0, 8'hFF, 8'h00);
    // Full 64-bit lane: carry must cross bit 32
    send_x(2'b00, 1'b0, 4'd3, 64'h0000_0000_FFFF_FFFF, 64'h1,
           64'h0000_0001_0000_0000, 8'h00, 8'h00);
    // Signed 16-bit positive overflow
    send_x(2'b10, 1'b1, 4'd1, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0001_0001_0001_0001,
           64'h7FFF_7FFF_7FFF_7FFF, 8'h00, 8'hAA);
    drain();
    @(negedge clk);
    check("sticky_set", 64'(sat_sticky_o), 64'd1);
    repeat (3) @(negedge clk);
    check("sticky_hold", 64'(sat_sticky_o), 64'd1);
    clr_sat_i = 1'b1;
    @(negedge clk);
    clr_sat_i = 1'b0;
    check("sticky_clr", 64'(sat_sticky_o), 64'd0);

    // Clear coincident with a new saturating output transfer: set wins
    @(posedge clk);
    #1;
    send_m(2'b11, 1'b1, 4'd0, 64'h8080_8080_8080_8080, 64'h0101_0101_0101_0101, 1'b1);
    wait_valid("sat_out_valid");
    clr_sat_i = 1'b1;
    @(posedge clk);
    #1 clr_sat_i = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", 64'(sat_sticky_o), 64'd1);
    @(posedge clk);
    #1;

    // Unsigned 32-bit borrow clamps to zero
    send_x(2'b11, 1'b0, 4'd2, 64'h0000_0005_0000_0005, 64'h0000_0007_0000_0007,
           64'h0, 8'h00, 8'h88);
    drain();
    @(posedge clk);
    #1;

    // Reset with two transactions in flight
    ready_i = 1'b0;
    send_m(2'b00, 1'b0, 4'd0, 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0);
    send_m(2'b01, 1'b0, 4'd1, 64'h5555_6666_7777_8888, 64'h0123_4567_89AB_CDEF, 1'b0);
    check("inflight_valid_o", 64'(valid_o), 64'd1);
    check("sticky_pre_rst", 64'(sat_sticky_o), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("midrst_valid_o", 64'(valid_o), 64'd0);
    check("midrst_sticky", 64'(sat_sticky_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    check("midrst_ready_o", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1 ready_i = 1'b1;
    base = n_out;
    send_m(2'b00, 1'b0, 4'd2, 64'h0000_0010_FFFF_FFF0, 64'h0000_0020_0000_0020, 1'b1);
    drain();
    check("post_rst_count", 64'(n_out - base), 64'd1);
    @(posedge clk);
    #1;

    // Stream of 4 with a 3-cycle stall after the first result
    base = n_out;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_m(2'b00, 1'b0, 4'd0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0);
      end
      begin
        wait_valid("stream_first_valid");
        @(posedge clk);
        #1 ready_i = 1'b0;
        @(negedge clk);
        held = result_o;
        repeat (2) @(negedge clk);
        check("stall_valid_o", 64'(valid_o), 64'd1);
        check("stall_ready_o", 64'(ready_o), 64'd0);
        check("stall_stable", result_o, held);
        @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    drain();
    check("stream_count", 64'(n_out - base), 64'd4);
    @(posedge clk);
    #1;

    // Random mix with random back-pressure, including oversized sew
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++)
          send_m(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 6)),
                 rnd_operand(), rnd_operand(), 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if (!done) ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_i = 1'b1;
    drain();
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simd_addsub_pipe.md
Name: simd_addsub_pipe

Overview:
Parametrised, pipelined successor to the combinational SIMD adder. It performs lane-split add/subtract over a MAX_WIDTH datapath, with lane width selected per transaction by sew, and optional signed or unsigned saturation. A 2-stage valid/ready pipeline wraps the datapath, together with per-lane carry and saturation flags and a sticky saturation status bit. It sits between the vector operand read stage and the writeback arbiter.

Parameters:
MIN_WIDTH, 8, narrowest lane width in bits (power of 2)
MAX_WIDTH, 64, datapath width in bits (power of 2, >= MIN_WIDTH)
RATIO, MAX_WIDTH/MIN_WIDTH, number of narrowest-lane slots (derived, not overridable)
SEW_WIDTH, $clog2(RATIO)+1, width of sew field (derived)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
valid_i  input  1  input transaction valid
ready_o  output  1  block can accept an input this cycle
op_i  input  2  00 ADD, 01 SUB (A-B), 10 ADD_SAT, 11 SUB_SAT
signed_i  input  1  saturation bounds: 1 signed, 0 unsigned
sew_i  input  SEW_WIDTH  lane width = MIN_WIDTH << sew_i
opA_i  input  MAX_WIDTH  operand A
opB_i  input  MAX_WIDTH  operand B
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
result_o  output  MAX_WIDTH  lane-wise result
carry_o  output  RATIO  per-slot raw carry-out; set only in the top slot of each lane
satf_o  output  RATIO  per-slot saturation-applied flag; set only in the top slot of each lane
sat_sticky_o  output  1  sticky OR of all accepted saturation events
clr_sat_i  input  1  clears sat_sticky_o

Behaviour:
- Transfer on the input side when valid_i && ready_o. Transfer on the output side when valid_o && ready_i.
- Stage S1 registers the operands and control. Stage S2 holds the computed result and flags.
- Latency: exactly 2 cycles from input transfer to valid_o with ready_i held high. Throughput is 1 per cycle.
- Advance rules:
  - S2 loads when !s2_valid || ready_i.
  - S1 loads when !s1_valid || S2 loads.
  - ready_o = !s1_valid || S2 loads. This is combinational from ready_i, so there is no bubble under continuous flow.
- Back-pressure: with ready_i low, at most 2 transactions are held. Data and order are preserved. Outputs are stable while valid_o && !ready_i.
- sew_i values greater than $clog2(RATIO) are treated as full MAX_WIDTH.
- Lane arithmetic is computed as A + (sub ? ~B : B) + sub.
  - Carries propagate within a lane and are cut at every lane boundary.
  - Each lane computes at its own width.
- carry_o is the raw carry out of the lane MSB. For SUB it is 1 when no borrow occurs.
- Saturation (op_i[1]=1):
  - Unsigned add: a carry clamps the lane to all-ones.
  - Unsigned sub: a borrow clamps the lane to 0.
  - Signed add/sub: overflow (operand signs vs. result sign) clamps to 0x7F..F when positive overflow and 0x80..0 when negative overflow.
  - satf_o is set in the lane's top slot when a clamp is applied.
- Non-saturating ops: result wraps and satf_o = 0. signed_i is ignored.
- sat_sticky_o:
  - Set on the cycle after an output transfer with |satf_o.
  - Cleared by clr_sat_i.
  - If set and clear occur in the same cycle, set wins.
- Reset: s1_valid = 0, s2_valid = 0, valid_o = 0, result_o = 0, carry_o = 0, satf_o = 0, sat_sticky_o = 0. ready_o is 1 the cycle after reset deasserts.
- Reset mid-operation drops all in-flight transactions. No partial output is produced.
- While rst is high, ready_o = 0.
- Data registers are loaded only on stage advance. valid_o deasserts after its final transfer if no new data follows.

Test Plan:
- MAX=64, MIN=8, sew=0, ADD, A=0xFFFF_FFFF_FFFF_FFFF, B=0x0101_0101_0101_0101 -> result 0x0, carry_o=0xFF, satf_o=0x00, valid_o 2 cycles after transfer.
- sew=3, ADD, A=0x0000_0000_FFFF_FFFF, B=0x1 -> result 0x0000_0001_0000_0000, carry_o=0x00 (no lane cut at bit 32).
- sew=1, ADD_SAT, signed, all lanes A=0x7FFF, B=0x0001 -> result 0x7FFF_7FFF_7FFF_7FFF, satf_o=0xAA, then sat_sticky_o=1 and held until a clr_sat_i pulse (simultaneous clr plus new sat event -> stays 1).
- sew=2, SUB_SAT, unsigned, lanes A=5, B=7 -> result 0x0, satf_o=0x88, carry_o=0x00.
- Stream 4 ADD transactions, ready_i low for 3 cycles after the first valid_o -> ready_o falls once S1 and S2 are both full, all 4 results emerge in order, none duplicated.
- Assert rst for 1 cycle with 2 transactions in flight -> valid_o=0 and sat_sticky_o=0 next cycle, no stale result emitted, a new transfer completes with 2-cycle latency.
